// File: rtl/dac_wave_scheduler_pkg.sv
// Shared types and constants for the PMOD DAC sample path.
// Mode encodings, DAC byte limits and the mode-advance helper.
package dac_wave_scheduler_pkg;

    localparam int DAC_WIDTH = 8;
    localparam logic [DAC_WIDTH-1:0] DAC_MIN = 8'h00;
    localparam logic [DAC_WIDTH-1:0] DAC_MAX = 8'hFF;

    typedef enum logic [1:0] {
        MODE_MANUAL   = 2'd0,
        MODE_RAMP     = 2'd1,
        MODE_TRIANGLE = 2'd2,
        MODE_SQUARE   = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    function automatic mode_e next_mode(input mode_e m);
        mode_e r;
        unique case (m)
            MODE_MANUAL:   r = MODE_RAMP;
            MODE_RAMP:     r = MODE_TRIANGLE;
            MODE_TRIANGLE: r = MODE_SQUARE;
            MODE_SQUARE:   r = MODE_MANUAL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Enable-gated clock divider; pulses o_Tick on the last count of each
// CLKS_PER_SAMPLE period.
module sample_tick_gen #(
    parameter int CLKS_PER_SAMPLE = 25
) (
    input  logic i_Clk,
    input  logic i_Reset,
    input  logic i_Enable,
    output logic o_Tick
);

    localparam int W = (CLKS_PER_SAMPLE > 2) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam logic [W-1:0] LAST = W'(CLKS_PER_SAMPLE - 1);

    logic [W-1:0] div_q;
    logic [W-1:0] div_d;

    always_comb begin
        div_d  = div_q;
        o_Tick = 1'b0;
        if (i_Enable) begin
            if (div_q == LAST) begin
                div_d  = '0;
                o_Tick = 1'b1;
            end else begin
                div_d = div_q + W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) div_q <= '0;
        else         div_q <= div_d;
    end

endmodule

// File: rtl/dac_wave_scheduler.sv
// Waveform sequencer for the PMOD DAC: one sample per tick, button
// cycles MANUAL -> RAMP -> TRIANGLE -> SQUARE.
module dac_wave_scheduler
    import dac_wave_scheduler_pkg::*;
#(
    parameter int CLKS_PER_SAMPLE = 25,
    parameter int STEP            = 1,
    parameter int SQUARE_HALF     = 128
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic       i_Enable,
    input  logic       i_Mode_Button,
    input  logic [7:0] i_Manual_Byte,
    output logic [7:0] o_Dac_Byte,
    output logic       o_Sample_Strobe,
    output logic [1:0] o_Mode
);

    localparam int SQ_W = (2 * SQUARE_HALF > 2) ? $clog2(2 * SQUARE_HALF) : 1;
    localparam logic [SQ_W-1:0] SQ_HALF = SQ_W'(SQUARE_HALF);
    localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(2 * SQUARE_HALF - 1);
    localparam logic [7:0] STEP8 = 8'(STEP);

    logic tick;

    sample_tick_gen #(
        .CLKS_PER_SAMPLE(CLKS_PER_SAMPLE)
    ) u_tick (
        .i_Clk   (i_Clk),
        .i_Reset (i_Reset),
        .i_Enable(i_Enable),
        .o_Tick  (tick)
    );

    mode_e            mode_q, mode_d, cur_mode;
    dir_e             dir_q, dir_d, cur_dir;
    logic [7:0]       acc_q, acc_d, cur_acc;
    logic [SQ_W-1:0]  sq_q, sq_d, cur_sq;
    logic [7:0]       byte_q, byte_d;
    logic             strobe_q, strobe_d;
    logic             pend_q, pend_d;
    logic             btn_q;
    logic             rise;
    logic [8:0]       sum;

    assign rise = i_Mode_Button & ~btn_q;

    always_comb begin
        mode_d   = mode_q;
        dir_d    = dir_q;
        acc_d    = acc_q;
        sq_d     = sq_q;
        byte_d   = byte_q;
        strobe_d = 1'b0;
        pend_d   = pend_q | rise;
        cur_mode = mode_q;
        cur_dir  = dir_q;
        cur_acc  = acc_q;
        cur_sq   = sq_q;
        sum      = 9'd0;
        if (tick) begin
            strobe_d = 1'b1;
            // an edge on the tick clock itself waits for the next tick
            pend_d   = rise;
            if (pend_q) begin
                cur_mode = next_mode(mode_q);
                cur_dir  = DIR_UP;
                cur_acc  = DAC_MIN;
                cur_sq   = '0;
            end
            mode_d = cur_mode;
            dir_d  = cur_dir;
            acc_d  = cur_acc;
            sq_d   = cur_sq;
            unique case (cur_mode)
                MODE_MANUAL: byte_d = i_Manual_Byte;
                MODE_RAMP: begin
                    byte_d = cur_acc;
                    acc_d  = cur_acc + STEP8;
                end
                MODE_TRIANGLE: begin
                    byte_d = cur_acc;
                    if (cur_dir == DIR_UP) begin
                        sum = {1'b0, cur_acc} + {1'b0, STEP8};
                        if (sum >= 9'd255) begin
                            acc_d = DAC_MAX;
                            dir_d = DIR_DOWN;
                        end else begin
                            acc_d = sum[7:0];
                        end
                    end else if (cur_acc <= STEP8) begin
                        acc_d = DAC_MIN;
                        dir_d = DIR_UP;
                    end else begin
                        acc_d = cur_acc - STEP8;
                    end
                end
                MODE_SQUARE: begin
                    byte_d = (cur_sq < SQ_HALF) ? DAC_MIN : DAC_MAX;
                    sq_d   = (cur_sq == SQ_LAST) ? '0 : cur_sq + SQ_W'(1);
                end
            endcase
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            mode_q   <= MODE_MANUAL;
            dir_q    <= DIR_UP;
            acc_q    <= DAC_MIN;
            sq_q     <= '0;
            byte_q   <= DAC_MIN;
            strobe_q <= 1'b0;
            pend_q   <= 1'b0;
            btn_q    <= i_Mode_Button;
        end else begin
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            acc_q    <= acc_d;
            sq_q     <= sq_d;
            byte_q   <= byte_d;
            strobe_q <= strobe_d;
            pend_q   <= pend_d;
            btn_q    <= i_Mode_Button;
        end
    end

    assign o_Dac_Byte      = byte_q;
    assign o_Sample_Strobe = strobe_q;
    assign o_Mode          = mode_q;

endmodule
